// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: takes one word per fetch handshake, decodes fields, immediate
// and operation class into a single output register handed to execute via valid/ready.
module rv32i_decode_stage #(
  parameter logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013,
  parameter logic [31:0] RESET_PC         = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_instruction,
  input  logic [31:0] i_fetch_pc,
  output logic        o_decode_ready,
  input  logic        i_flush,
  output logic        o_decode_valid,
  input  logic        i_execute_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [2:0]  o_funct3,
  output logic        o_funct7_b5,
  output logic [31:0] o_imm,
  output logic [3:0]  o_op_class,
  output logic        o_illegal
);

  localparam logic [3:0] CLS_OP       = 4'd0;
  localparam logic [3:0] CLS_OP_IMM   = 4'd1;
  localparam logic [3:0] CLS_LOAD     = 4'd2;
  localparam logic [3:0] CLS_STORE    = 4'd3;
  localparam logic [3:0] CLS_BRANCH   = 4'd4;
  localparam logic [3:0] CLS_JAL      = 4'd5;
  localparam logic [3:0] CLS_JALR     = 4'd6;
  localparam logic [3:0] CLS_LUI      = 4'd7;
  localparam logic [3:0] CLS_AUIPC    = 4'd8;
  localparam logic [3:0] CLS_MISC_MEM = 4'd9;
  localparam logic [3:0] CLS_SYSTEM   = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL  = 4'd15;

  function automatic logic [3:0] decode_class(input logic [31:0] instr);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] cls;
    f3  = instr[14:12];
    f7  = instr[31:25];
    cls = CLS_ILLEGAL;
    if (instr[1:0] != 2'b11) begin
      cls = CLS_ILLEGAL;
    end else begin
      case (instr[6:0])
        7'b0110011: begin
          if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) cls = CLS_OP;
          else cls = CLS_ILLEGAL;
        end
        7'b0010011: begin
          // Shift-immediates reuse the top bits as a funct7; only srai may set bit 30.
          if (f3 == 3'b001) cls = (f7 == 7'h00) ? CLS_OP_IMM : CLS_ILLEGAL;
          else if (f3 == 3'b101) cls = (f7 == 7'h00 || f7 == 7'h20) ? CLS_OP_IMM : CLS_ILLEGAL;
          else cls = CLS_OP_IMM;
        end
        7'b0000011: begin
          if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) cls = CLS_ILLEGAL;
          else cls = CLS_LOAD;
        end
        7'b0100011: cls = (f3 >= 3'b011) ? CLS_ILLEGAL : CLS_STORE;
        7'b1100011: begin
          if (f3 == 3'b010 || f3 == 3'b011) cls = CLS_ILLEGAL;
          else cls = CLS_BRANCH;
        end
        7'b1101111: cls = CLS_JAL;
        7'b1100111: cls = (f3 == 3'b000) ? CLS_JALR : CLS_ILLEGAL;
        7'b0110111: cls = CLS_LUI;
        7'b0010111: cls = CLS_AUIPC;
        7'b0001111: cls = CLS_MISC_MEM;
        7'b1110011: cls = CLS_SYSTEM;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  function automatic logic [31:0] decode_imm(input logic [31:0] instr, input logic [3:0] cls);
    logic [31:0] imm;
    case (cls)
      CLS_OP_IMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM, CLS_MISC_MEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC: imm = {instr[31:12], 12'd0};
      CLS_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:    imm = 32'd0;
    endcase
    return imm;
  endfunction

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [4:0]  rd_r;
  logic [2:0]  funct3_r;
  logic        funct7_b5_r;
  logic [31:0] imm_r;
  logic [3:0]  class_r;
  logic        illegal_r;

  logic        ready_s;
  logic        accept_s;
  logic [3:0]  next_class_s;
  logic [31:0] next_imm_s;

  // Handshake qualification and decode of the incoming word.
  always_comb begin
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    next_class_s = decode_class(i_fetch_instruction);
    next_imm_s   = decode_imm(i_fetch_instruction, next_class_s);
    if (!i_rst && !i_flush && (!valid_r || i_execute_ready)) ready_s = 1'b1;
    else ready_s = 1'b0;
    accept_s = ready_s && i_fetch_valid;
  end

  // Output pipeline register: reset beats flush, flush beats accept/drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r     <= 1'b0;
      instr_r     <= NOOP_INSTRUCTION;
      pc_r        <= RESET_PC;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      rd_r        <= 5'd0;
      funct3_r    <= 3'd0;
      funct7_b5_r <= 1'b0;
      imm_r       <= 32'd0;
      class_r     <= CLS_OP_IMM;
      illegal_r   <= 1'b0;
    end else if (i_flush) begin
      valid_r   <= 1'b0;
      instr_r   <= NOOP_INSTRUCTION;
      class_r   <= CLS_OP_IMM;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      valid_r     <= 1'b1;
      instr_r     <= i_fetch_instruction;
      pc_r        <= i_fetch_pc;
      rs1_r       <= i_fetch_instruction[19:15];
      rs2_r       <= i_fetch_instruction[24:20];
      rd_r        <= i_fetch_instruction[11:7];
      funct3_r    <= i_fetch_instruction[14:12];
      funct7_b5_r <= i_fetch_instruction[30];
      imm_r       <= next_imm_s;
      class_r     <= next_class_s;
      illegal_r   <= (next_class_s == CLS_ILLEGAL);
    end else if (valid_r && i_execute_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign o_decode_ready = ready_s;
  assign o_decode_valid = valid_r;
  assign o_instruction  = instr_r;
  assign o_pc           = pc_r;
  assign o_rs1_addr     = rs1_r;
  assign o_rs2_addr     = rs2_r;
  assign o_rd_addr      = rd_r;
  assign o_funct3       = funct3_r;
  assign o_funct7_b5    = funct7_b5_r;
  assign o_imm          = imm_r;
  assign o_op_class     = class_r;
  assign o_illegal      = illegal_r;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: table of hand-decoded words fed through a scoreboard,
// plus hand-written backpressure, flush and reset-mid-hold sequences.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        decode_ready;
  logic        flush;
  logic        decode_valid;
  logic        exec_ready;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm;
  logic [3:0]  op_class;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [31:0] pc;
  } exp_t;

  exp_t vecs[16];
  exp_t sb[$];

  rv32i_decode_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_fetch_valid(fetch_valid), .i_fetch_instruction(fetch_instr), .i_fetch_pc(fetch_pc),
    .o_decode_ready(decode_ready), .i_flush(flush),
    .o_decode_valid(decode_valid), .i_execute_ready(exec_ready),
    .o_instruction(instr_o), .o_pc(pc_o),
    .o_rs1_addr(rs1), .o_rs2_addr(rs2), .o_rd_addr(rd),
    .o_funct3(funct3), .o_funct7_b5(funct7_b5), .o_imm(imm),
    .o_op_class(op_class), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [2:0] f3, input logic f7,
                              input logic [31:0] im, input logic [3:0] c);
    exp_t e;
    e.instr = w; e.rs1 = r1; e.rs2 = r2; e.rd = d; e.f3 = f3; e.f7b5 = f7;
    e.imm = im; e.cls = c; e.pc = 32'd0;
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    chk("instr", instr_o, e.instr);
    chk("pc", pc_o, e.pc);
    chk("rs1", {27'd0, rs1}, {27'd0, e.rs1});
    chk("rs2", {27'd0, rs2}, {27'd0, e.rs2});
    chk("rd", {27'd0, rd}, {27'd0, e.rd});
    chk("funct3", {29'd0, funct3}, {29'd0, e.f3});
    chk("funct7_b5", {31'd0, funct7_b5}, {31'd0, e.f7b5});
    chk("imm", imm, e.imm);
    chk("op_class", {28'd0, op_class}, {28'd0, e.cls});
    chk("illegal", {31'd0, illegal}, {31'd0, (e.cls == 4'd15)});
  endtask

  // Scoreboard monitor: every execute handshake must match the oldest accepted word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && decode_valid && exec_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", instr_o, 32'hxxxxxxxx);
      end else begin
        e = sb.pop_front();
        check_out(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for a cycle; push it as expected only if the stage takes it.
  task automatic send(input exp_t e, input bit must_take);
    fetch_valid = 1'b1;
    fetch_instr = e.instr;
    fetch_pc    = e.pc;
    @(negedge clk);
    if (must_take) chk("ready_on_send", {31'd0, decode_ready}, 32'd1);
    if (decode_ready) sb.push_back(e);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t a, b, c;
    vecs[0]  = mk(32'hFFF08293, 5'd1,  5'd31, 5'd5,  3'd0, 1'b1, 32'hFFFFFFFF, 4'd1);
    vecs[1]  = mk(32'hFE208CE3, 5'd1,  5'd2,  5'd25, 3'd0, 1'b1, 32'hFFFFFFF8, 4'd4);
    vecs[2]  = mk(32'h123451B7, 5'd8,  5'd3,  5'd3,  3'd5, 1'b0, 32'h12345000, 4'd7);
    vecs[3]  = mk(32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000, 4'd15);
    vecs[4]  = mk(32'h02000033, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000, 4'd15);
    vecs[5]  = mk(32'h40000033, 5'd0,  5'd0,  5'd0,  3'd0, 1'b1, 32'h00000000, 4'd0);
    vecs[6]  = mk(32'h00112623, 5'd2,  5'd1,  5'd12, 3'd2, 1'b0, 32'h0000000C, 4'd3);
    vecs[7]  = mk(32'h008000EF, 5'd0,  5'd8,  5'd1,  3'd0, 1'b0, 32'h00000008, 4'd5);
    vecs[8]  = mk(32'h000010E7, 5'd0,  5'd0,  5'd1,  3'd1, 1'b0, 32'h00000000, 4'd15);
    vecs[9]  = mk(32'hFFC12303, 5'd2,  5'd28, 5'd6,  3'd2, 1'b1, 32'hFFFFFFFC, 4'd2);
    vecs[10] = mk(32'h4030D093, 5'd1,  5'd3,  5'd1,  3'd5, 1'b1, 32'h00000403, 4'd1);
    vecs[11] = mk(32'h40309093, 5'd1,  5'd3,  5'd1,  3'd1, 1'b1, 32'h00000000, 4'd15);
    vecs[12] = mk(32'hFFFFF517, 5'd31, 5'd31, 5'd10, 3'd7, 1'b1, 32'hFFFFF000, 4'd8);
    vecs[13] = mk(32'h00000012, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000, 4'd15);
    vecs[14] = mk(32'h00000073, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000, 4'd10);
    vecs[15] = mk(32'h0FF0000F, 5'd0,  5'd31, 5'd0,  3'd0, 1'b0, 32'h000000FF, 4'd9);
    for (int i = 0; i < 16; i++) vecs[i].pc = 32'h100 + 32'(i) * 32'd4;

    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = 32'd0; fetch_pc = 32'd0;
    exec_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, decode_valid}, 32'd0);
    chk("rst_instr", instr_o, 32'h00000013);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_ready", {31'd0, decode_ready}, 32'd1);
    chk("rst_class", {28'd0, op_class}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_fields", {17'd0, rs1, rs2, rd}, 32'd0);
    step();

    // Back-to-back stream at full throughput; ready must stay high.
    for (int i = 0; i < 16; i++) send(vecs[i], 1'b1);
    fetch_valid = 1'b0;
    step();
    chk("stream_drained", sb.size(), 32'd0);

    // Backpressure: hold A for 3 cycles while B waits, then swap in one cycle.
    a = vecs[0]; a.pc = 32'h200;
    b = vecs[2]; b.pc = 32'h204;
    exec_ready = 1'b0;
    send(a, 1'b1);
    for (int k = 0; k < 3; k++) begin
      fetch_valid = 1'b1; fetch_instr = b.instr; fetch_pc = b.pc;
      @(negedge clk);
      chk("hold_ready", {31'd0, decode_ready}, 32'd0);
      chk("hold_valid", {31'd0, decode_valid}, 32'd1);
      chk("hold_instr", instr_o, a.instr);
      chk("hold_pc", pc_o, a.pc);
      chk("hold_imm", imm, a.imm);
      step();
    end
    exec_ready = 1'b1;
    send(b, 1'b1);
    fetch_valid = 1'b0;
    @(negedge clk);
    step();
    chk("swap_valid", {31'd0, decode_valid}, 32'd0);
    chk("swap_drained", sb.size(), 32'd0);

    // Flush while full with a word offered: both are dropped.
    c = vecs[6]; c.pc = 32'h300;
    exec_ready = 1'b0;
    send(c, 1'b1);
    fetch_valid = 1'b1; fetch_instr = vecs[9].instr; fetch_pc = 32'h304; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", {31'd0, decode_ready}, 32'd0);
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_valid", {31'd0, decode_valid}, 32'd0);
    chk("flush_instr", instr_o, 32'h00000013);
    chk("flush_class", {28'd0, op_class}, 32'd1);
    chk("flush_illegal", {31'd0, illegal}, 32'd0);
    chk("flush_pc_kept", pc_o, 32'h300);
    chk("flush_rd_kept", {27'd0, rd}, 32'd12);
    exec_ready = 1'b1;
    step(); step();
    chk("flush_no_capture", {31'd0, decode_valid}, 32'd0);

    // Reset mid-hold drops the held word and restores reset values.
    exec_ready = 1'b0;
    send(vecs[12], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_ready", {31'd0, decode_ready}, 32'd0);
    step();
    rst = 1'b0;
    sb.delete();
    exec_ready = 1'b1;
    @(negedge clk);
    chk("rst2_valid", {31'd0, decode_valid}, 32'd0);
    chk("rst2_pc", pc_o, 32'd0);
    chk("rst2_imm", imm, 32'd0);
    chk("rst2_instr", instr_o, 32'h00000013);
    chk("rst2_rd", {27'd0, rd}, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Consumer end of the fetch→decode handshake. Accepts one instruction and its PC per transfer from the instruction fetch stage, and decodes it into RV32I fields, an immediate and an operation class.
- Holds the result in a single output pipeline register presented to execute with a valid/ready handshake.
- Discards held work on a branch-miss flush.

Parameters:
- NOOP_INSTRUCTION, 32'h0000_0013, instruction word reported in o_instruction when the stage is empty (addi x0,x0,0).
- RESET_PC, 32'd0, value of o_pc after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_fetch_valid  in  1  fetch holds a valid instruction (fetch o_instruction_ready).
- i_fetch_instruction  in  32  instruction word.
- i_fetch_pc  in  32  PC of instruction word.
- o_decode_ready  out  1  stage can accept this cycle (to fetch i_decode_ready).
- i_flush  in  1  branch miss; kill held and incoming instruction.
- o_decode_valid  out  1  output register holds a decoded instruction.
- i_execute_ready  in  1  execute accepts this cycle.
- o_instruction  out  32  raw held word.
- o_pc  out  32  PC of held word.
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  5 each  register fields (bits 19:15, 24:20, 11:7).
- o_funct3  out  3  bits 14:12.
- o_funct7_b5  out  1  bit 30.
- o_imm  out  32  sign-extended immediate.
- o_op_class  out  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 MISC_MEM, 10 SYSTEM, 15 ILLEGAL.
- o_illegal  out  1  o_op_class==15.

Behaviour:
- State: EMPTY / FULL, carried by o_decode_valid.
- o_decode_ready = !i_rst && !i_flush && (!o_decode_valid || i_execute_ready). This is combinational and never depends on i_fetch_valid.
- Accept: i_fetch_valid && o_decode_ready at a rising edge. Decoded fields are registered and o_decode_valid=1 on the next cycle. Latency is 1 cycle.
- Drain: o_decode_valid && i_execute_ready with no accept gives o_decode_valid=0 next cycle. A simultaneous drain and accept replaces the contents, giving full throughput of 1 instruction/cycle.
- Hold: o_decode_valid && !i_execute_ready. All outputs are held stable and o_decode_ready=0.
- Flush: takes priority over accept and drain.
  - Next cycle o_decode_valid=0.
  - o_instruction=NOOP_INSTRUCTION and o_op_class=1.
  - Other registered fields keep their last values.
  - No instruction is taken in the flush cycle.
- Reset takes priority over flush. Next cycle:
  - o_decode_valid=0, o_instruction=NOOP_INSTRUCTION, o_pc=RESET_PC, o_op_class=1, o_illegal=0.
  - All field outputs and o_imm are 0.
- Reset or flush mid-hold drops the held instruction; execute must not see it again.
- Opcode map (bits 6:0):
  - 0110011→OP, 0010011→OP_IMM, 0000011→LOAD, 0100011→STORE, 1100011→BRANCH.
  - 1101111→JAL, 1100111→JALR, 0110111→LUI, 0010111→AUIPC, 0001111→MISC_MEM, 1110011→SYSTEM.
  - Any other opcode → ILLEGAL.
- Additional ILLEGAL cases:
  - bits 1:0 != 2'b11.
  - OP with funct7 ∉ {0x00, 0x20}, or funct7=0x20 with funct3 ∉ {000, 101}.
  - OP_IMM shift (funct3 001/101) with bits 31:25 ∉ {0x00, 0x20}, or 0x20 with funct3=001.
  - LOAD funct3 ∈ {011, 110, 111}; STORE funct3 >= 011; BRANCH funct3 ∈ {010, 011}; JALR funct3 != 000.
- Illegal instructions are still accepted and passed downstream with o_illegal=1; the stage does not stall on them.
- Immediate forms; all are sign-extended from bit 31 and o_imm is 0 for OP and ILLEGAL:
  - I (OP_IMM, LOAD, JALR, SYSTEM): {20{b31}, b31:20}.
  - S: {20{b31}, b31:25, b11:7}.
  - B: {19{b31}, b31, b7, b30:25, b11:8, 0}.
  - U (LUI, AUIPC): {b31:12, 12'b0}.
  - J: {11{b31}, b31, b19:12, b20, b30:21, 0}.
  - MISC_MEM: I-form.
- Register fields are passed through raw regardless of class.

Test Plan:
- Reset held 2 cycles, then released with i_fetch_valid=0 → o_decode_valid=0, o_instruction=32'h00000013, o_pc=0, o_decode_ready=1.
- Accept 0xFFF08293 at PC 0x100 → next cycle valid=1, rs1=1, rd=5, funct3=0, op_class=1, o_imm=0xFFFFFFFF, o_pc=0x100.
- 0xFE208CE3 (beq x1,x2,-8) then 0x123451B7 (lui x3,0x12345) back-to-back with i_execute_ready=1 → consecutive cycles show op_class 4 / imm 0xFFFFFFF8, then op_class 7 / rd=3 / imm 0x12345000; o_decode_ready stays 1 throughout.
- Backpressure: valid held instruction with i_execute_ready=0 for 3 cycles → outputs frozen, o_decode_ready=0; i_execute_ready=1 with new fetch → swap in one cycle, with no loss or duplicate.
- i_flush while FULL and i_fetch_valid=1 → next cycle valid=0, o_instruction=0x13, incoming word not captured, o_decode_ready=0 during flush cycle.
- Illegal words 0x00000000 and 0x02000033 (funct7=1) → op_class=15, o_illegal=1, o_imm=0, valid=1; 0x40000033 (sub) → op_class=0, o_illegal=0.
